// File: rtl/fa_serial_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer driving a shared single-bit full adder, LSB first.
// Optional per-bit response timeout enabled by defining FA_TIMEOUT_EN.
module fa_serial_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic             fa_valid_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_valid_out,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             fa_a_d, fa_b_d, fa_c_d;
  logic             timeout_c;

  assign idx_inc  = idx_q + IDX_W'(1);
  assign rsp_sum  = sum_q;
  assign rsp_cout = carry_q;

`ifdef FA_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1)) && !fa_valid_out;
  assign rsp_err   = err_q;

  // Per-bit wait counter and sticky abort flag, cleared by the response handshake
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        if (!fa_valid_out) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_c) err_d = 1'b1;
        end
      end
      ST_DONE: if (rsp_ready) err_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign rsp_err        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Next-state and datapath updates; fa bit operands are prepared one cycle ahead of ISSUE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    fa_a_d  = fa_a;
    fa_b_d  = fa_b;
    fa_c_d  = fa_c;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          carry_d = req_cin;
          idx_d   = '0;
          sum_d   = '0;
          fa_a_d  = req_a[0];
          fa_b_d  = req_b[0];
          fa_c_d  = req_cin;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fa_valid_out) begin
          sum_d[idx_q] = fa_s;
          carry_d      = fa_cout;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_inc;
            fa_a_d  = a_q[idx_inc];
            fa_b_d  = b_q[idx_inc];
            fa_c_d  = fa_cout;
            state_d = ST_ISSUE;
          end
        end else if (timeout_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      fa_a        <= 1'b0;
      fa_b        <= 1'b0;
      fa_c        <= 1'b0;
      fa_valid_in <= 1'b0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      fa_a        <= fa_a_d;
      fa_b        <= fa_b_d;
      fa_c        <= fa_c_d;
      fa_valid_in <= (state_d == ST_ISSUE);
      rsp_valid   <= (state_d == ST_DONE);
      busy        <= (state_d != ST_IDLE);
      req_ready   <= (state_d == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Self-checking bench for fa_serial_ctrl: behavioural adder, transaction-level model, directed vectors.
module tb_fa_serial_ctrl;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready, req_cin = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0, rsp_sum;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_err;
  logic         fa_valid_in, fa_a, fa_b, fa_c;
  logic         fa_valid_out = 1'b0, fa_s = 1'b0, fa_cout = 1'b0;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int adder_lat = 1;
  int resp_left = 1 << 30;

  fa_serial_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .fa_valid_in(fa_valid_in), .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_valid_out(fa_valid_out), .fa_s(fa_s), .fa_cout(fa_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Carry into bit k of a+b+cin, straight from arithmetic.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    int unsigned msk, s;
    msk = (32'd1 << k) - 32'd1;
    s   = (32'(a) & msk) + (32'(b) & msk) + 32'(c);
    return 1'(s >> k);
  endfunction

  // Behavioural full adder with adder_lat cycles of latency; stops answering when resp_left hits 0.
  initial begin
    int cd;
    logic ps, pc;
    cd = 0; ps = 1'b0; pc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cd = 0;
        fa_valid_out = 1'b0;
      end else begin
        fa_valid_out = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            fa_valid_out = 1'b1;
            fa_s = ps;
            fa_cout = pc;
          end
        end
        if (fa_valid_in && resp_left > 0) begin
          cd = adder_lat;
          ps = fa_a ^ fa_b ^ fa_c;
          pc = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
          resp_left--;
        end
      end
    end
  end

  // Transaction-level model: checks every output on every cycle.
  bit           m_busy = 1'b0;
  int           m_acc, m_lat, m_k, m_total, m_last, t, kk;
  logic [W-1:0] m_a, m_b, m_sum;
  logic         m_cin, m_cout, m_err, exp_iss;
  logic [2:0]   last_abc;
  int unsigned  m_full;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_fa_valid_in", 64'(fa_valid_in), 64'(0));
      chk("rst_fa_abc", 64'({fa_a, fa_b, fa_c}), 64'(0));
      chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
      chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    end else if (!m_busy) begin
      chk("idle_req_ready", 64'(req_ready), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("idle_fa_valid_in", 64'(fa_valid_in), 64'(0));
      if (req_valid) begin
        m_busy = 1'b1;
        m_acc  = cyc + 1;
        m_a = req_a; m_b = req_b; m_cin = req_cin;
        m_lat  = adder_lat;
        m_k    = (resp_left < W) ? resp_left : W;
        m_full = 32'(m_a) + 32'(m_b) + 32'(m_cin);
        if (m_k >= W) begin
          m_total = 1 + W * (m_lat + 1);
          m_sum   = W'(m_full);
          m_cout  = 1'(m_full >> W);
          m_err   = 1'b0;
          m_last  = W - 1;
        end else begin
          m_total = 2 + m_k * (m_lat + 1) + TO;
          m_sum   = W'(m_full & ((32'd1 << m_k) - 32'd1));
          m_cout  = carry_into(m_a, m_b, m_cin, m_k);
          m_err   = 1'b1;
          m_last  = m_k;
        end
      end
    end else begin
      t = cyc - m_acc + 1;
      exp_iss = ((t - 1) % (m_lat + 1) == 0) && ((t - 1) / (m_lat + 1) <= m_last) && (t < m_total);
      chk("busy", 64'(busy), 64'(1));
      chk("req_ready", 64'(req_ready), 64'(0));
      chk("rsp_valid", 64'(rsp_valid), 64'(t >= m_total));
      chk("fa_valid_in", 64'(fa_valid_in), 64'(exp_iss));
      if (exp_iss) begin
        kk = (t - 1) / (m_lat + 1);
        last_abc = {m_a[kk], m_b[kk], carry_into(m_a, m_b, m_cin, kk)};
        chk("fa_abc_issue", 64'({fa_a, fa_b, fa_c}), 64'(last_abc));
      end else begin
        chk("fa_abc_hold", 64'({fa_a, fa_b, fa_c}), 64'(last_abc));
      end
      if (t >= m_total) begin
        chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
        chk("rsp_cout", 64'(rsp_cout), 64'(m_cout));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        if (rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // Present a command; returns the cycle number of the accept edge. Called just after a posedge.
  task automatic start_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           output int acc);
    bit ok;
    ok = 1'b0;
    req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("accept_wait", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  // Wait for the response, optionally stall rsp_ready for hold cycles, then handshake.
  task automatic wait_rsp(input int acc, input int hold, output logic [W-1:0] s,
                          output logic co, output logic er, output int lat, output int pulses);
    bit got;
    got = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fa_valid_in) pulses++;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("rsp_wait", 64'(got), 64'(1));
    lat = cyc - acc + 1;
    s = rsp_sum; co = rsp_cout; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
      chk("hold_busy", 64'(busy), 64'(1));
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    int acc, acc2, ret, lat, p, np;
    logic [W-1:0] s;
    logic co, er;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    start_cmd(8'hA5, 8'h3C, 1'b0, acc);
    wait_rsp(acc, 0, s, co, er, lat, p);
    chk("t1_sum", 64'(s), 64'(8'hE1));
    chk("t1_cout", 64'(co), 64'(0));
    chk("t1_latency", 64'(lat), 64'(17));
    chk("t1_pulses", 64'(p), 64'(8));

    start_cmd(8'hFF, 8'h01, 1'b0, acc);
    wait_rsp(acc, 0, s, co, er, lat, p);
    chk("t2_sum", 64'(s), 64'(8'h00));
    chk("t2_cout", 64'(co), 64'(1));

    start_cmd(8'hFF, 8'hFF, 1'b1, acc);
    wait_rsp(acc, 0, s, co, er, lat, p);
    chk("t3_sum", 64'(s), 64'(8'hFF));
    chk("t3_cout", 64'(co), 64'(1));
    chk("t3_latency", 64'(lat), 64'(17));

    adder_lat = 3;
    start_cmd(8'h0F, 8'h01, 1'b0, acc);
    wait_rsp(acc, 0, s, co, er, lat, p);
    chk("t4_sum", 64'(s), 64'(8'h10));
    chk("t4_cout", 64'(co), 64'(0));
    chk("t4_latency", 64'(lat), 64'(33));
    chk("t4_pulses", 64'(p), 64'(8));
    adder_lat = 1;

    // Response back-pressure with a new command already waiting
    start_cmd(8'h12, 8'h34, 1'b0, acc);
    req_a = 8'h80; req_b = 8'h80; req_cin = 1'b0; req_valid = 1'b1;
    wait_rsp(acc, 5, s, co, er, lat, p);
    chk("t5_sum", 64'(s), 64'(8'h46));
    chk("t5_cout", 64'(co), 64'(0));
    ret = cyc;
    start_cmd(8'h80, 8'h80, 1'b0, acc2);
    chk("t5_next_accept_edge", 64'(acc2), 64'(ret + 1));
    wait_rsp(acc2, 0, s, co, er, lat, p);
    chk("t5b_sum", 64'(s), 64'(8'h00));
    chk("t5b_cout", 64'(co), 64'(1));
    chk("t5b_latency", 64'(lat), 64'(17));

    // Reset while bit 3 is in flight
    start_cmd(8'hFF, 8'hFF, 1'b0, acc);
    np = 0;
    for (int i = 0; i < 100 && np < 4; i++) begin
      @(negedge clk);
      if (fa_valid_in) np++;
    end
    chk("t6_reached_bit3", 64'(np), 64'(4));
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_async_busy", 64'(busy), 64'(0));
    chk("t6_async_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t6_async_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    start_cmd(8'h01, 8'h01, 1'b0, acc);
    wait_rsp(acc, 0, s, co, er, lat, p);
    chk("t6_sum", 64'(s), 64'(8'h02));
    chk("t6_cout", 64'(co), 64'(0));
    chk("t6_err", 64'(er), 64'(0));

`ifdef FA_TIMEOUT_EN
    resp_left = 3;
    start_cmd(8'h07, 8'h00, 1'b0, acc);
    wait_rsp(acc, 0, s, co, er, lat, p);
    chk("t7_err", 64'(er), 64'(1));
    chk("t7_sum", 64'(s), 64'(8'h07));
    chk("t7_cout", 64'(co), 64'(0));
    chk("t7_latency", 64'(lat), 64'(24));
    chk("t7_pulses", 64'(p), 64'(4));
    resp_left = 1 << 30;
    @(negedge clk);
    chk("t7_err_cleared", 64'(rsp_err), 64'(0));
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fa_serial_ctrl.md
Name: fa_serial_ctrl

Overview:
- Bit-serial sequencer that adds two WIDTH-bit operands by driving the shared single-bit full-adder wrapper one bit per transaction, LSB first.
- The carry is held in a register between bit transactions.
- Sits between a requester (valid/ready command port) and the full-adder wrapper (valid_in/valid_out handshake).
- Returns the WIDTH-bit sum and carry-out on a valid/ready response port.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- TIMEOUT, 16, max cycles to wait for fa_valid_out per bit; used only with FA_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  requester has operands.
- req_ready  out  1  controller can accept a command.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  requester accepts result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  final carry-out.
- rsp_err  out  1  result aborted by timeout.
- fa_valid_in  out  1  bit operands valid to the full adder.
- fa_a  out  1  current bit of A.
- fa_b  out  1  current bit of B.
- fa_c  out  1  current carry.
- fa_valid_out  in  1  full adder result valid.
- fa_s  in  1  full adder sum bit.
- fa_cout  in  1  full adder carry bit.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; bit index, carry, operand, sum and rsp_cout registers = 0.
  - rsp_valid = 0, rsp_err = 0, fa_valid_in = 0, fa_a/fa_b/fa_c = 0, busy = 0.
  - req_ready = 1 (decoded from IDLE).
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: req_ready = 1. On req_valid && req_ready, latch req_a/req_b, carry <= req_cin, idx <= 0, sum <= 0, go to ISSUE. req_valid in any other state is ignored (no back-to-back accept from DONE).
  - ISSUE: fa_valid_in = 1 for exactly this one cycle. fa_a = A[idx], fa_b = B[idx], fa_c = carry. Go to WAIT.
  - WAIT: fa_valid_in = 0, and fa_a/fa_b/fa_c hold their values. On fa_valid_out: sum[idx] <= fa_s, carry <= fa_cout. If idx == WIDTH-1, go to DONE; else idx <= idx+1 and go to ISSUE. fa_valid_out is sampled only in WAIT and ignored in all other states.
  - DONE: rsp_valid = 1. rsp_sum = sum register, rsp_cout = carry. Outputs are held stable until rsp_valid && rsp_ready, then go to IDLE.
- Latency:
  - With a 1-cycle full adder, bit k is issued in cycle 2k+1 after the accept edge.
  - rsp_valid is first high 2*WIDTH+1 cycles after the accept edge (17 for WIDTH=8).
  - Each extra adder latency cycle adds WIDTH cycles.
- Width rule: rsp_sum is WIDTH bits and rsp_cout is the carry out of bit WIDTH-1. Together they equal A + B + cin.
- fa_valid_out arriving in the same cycle as the last bit's completion is handled identically to any other bit; no special case.
- Reset mid-operation aborts immediately to IDLE. No response is generated for the aborted command.

Optional Feature:
- Macro: FA_TIMEOUT_EN.
- Defined:
  - A per-bit counter clears on entry to WAIT and increments each WAIT cycle without fa_valid_out.
  - When it reaches TIMEOUT, go to DONE with rsp_err = 1. rsp_sum keeps the completed bits; remaining bits are 0. rsp_cout = current carry.
  - rsp_err clears on the rsp handshake and on reset.
- Undefined: no counter; WAIT waits indefinitely; rsp_err is tied to 0.

Test Plan:
- WIDTH=8, A=0xA5, B=0x3C, cin=0, 1-cycle adder -> rsp_sum=0xE1, rsp_cout=0, rsp_valid 17 cycles after accept, exactly 8 fa_valid_in pulses.
- A=0xFF, B=0x01, cin=0 -> rsp_sum=0x00, rsp_cout=1. A=0xFF, B=0xFF, cin=1 -> rsp_sum=0xFF, rsp_cout=1.
- Adder latency 3 cycles, A=0x0F, B=0x01, cin=0 -> rsp_sum=0x10, rsp_cout=0; rsp_valid 33 cycles after accept; fa_a/fa_b/fa_c stable through WAIT.
- Hold rsp_ready=0 for 5 cycles in DONE with req_valid=1 -> rsp_valid, rsp_sum and rsp_cout stable; req_ready=0; a new command is accepted only after the handshake returns to IDLE.
- Assert rst_n low during bit 3 of a transfer -> busy=0, rsp_valid=0, req_ready=1 immediately. The next command A=0x01, B=0x01, cin=0 -> rsp_sum=0x02.
- FA_TIMEOUT_EN, TIMEOUT=16: adder stops responding after bit 2 of A=0x07, B=0x00, cin=0 -> rsp_err=1, rsp_sum=0x07, rsp_cout=0, DONE entered 16 cycles after entering WAIT for bit 3.
